cordic_angle_reducer: RTL

CORDIC_ANGLE_REDUCER -- requirements
Module: cordic_angle_reducer

---
 rtl/cordic_angle_reducer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cordic_angle_reducer.sv
// cordic_angle_reducer
//   Folds a raw Q3.29 angle in [0, 8.0) rad into the first quadrant for a
//   CORDIC sequencer. It reports the quadrant of the original angle and the
//   angle offset back into [0, pi/2).
//   Fixed 4-cycle latency from the start edge to ready_reduce.
//   Sequence: IDLE -> LOAD -> WRAP -> CLASS -> SUB -> DONE -> IDLE.
//
//   Build option ANGLE_REDUCER_WRAP_EN:
//     defined   : angles >= 2*pi are wrapped by a single subtraction of 2*pi.
//     undefined : angles >= 2*pi are flagged on range_err and left unwrapped.
//   Latency is the same in both builds.
module cordic_angle_reducer (
  input  logic        clk,
  input  logic        reset,
  input  logic        beg_reduce,
  input  logic [31:0] angle_in,
  input  logic        ack_reduce,
  output logic [31:0] angle_out,
  output logic [1:0]  shift_region_flag,
  output logic        ready_reduce,
  output logic        range_err
);

  // Quadrant boundaries in Q3.29 radians.
  localparam logic [31:0] PI_2   = 32'h3243F6A9;
  localparam logic [31:0] PI     = 32'h6487ED51;
  localparam logic [31:0] PI3_2  = 32'h96CBE3FA;
  localparam logic [31:0] TWO_PI = 32'hC90FDAA2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRAP  = 3'd2,
    CLASS = 3'd3,
    SUB   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] a;          // working angle, captured at start
  logic [1:0]  quad_c;     // quadrant of the working angle
  logic [31:0] off_c;      // quadrant base selected by the registered flag
  logic        over_c;     // working angle at or beyond one full turn

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode. LOAD, WRAP, CLASS and SUB each take exactly one
  // cycle, so the latency does not depend on the data.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = beg_reduce ? LOAD : IDLE;
      LOAD:    state_nxt = WRAP;
      WRAP:    state_nxt = CLASS;
      CLASS:   state_nxt = SUB;
      SUB:     state_nxt = DONE;
      // ack returns to IDLE. A simultaneous beg_reduce is not seen here; it is
      // only sampled in IDLE, so no new operation starts on the same edge.
      DONE:    state_nxt = ack_reduce ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Quadrant classification and offset selection. An angle exactly on a
  // boundary belongs to the higher quadrant.
  always_comb begin
    over_c = (a >= TWO_PI);
    quad_c = 2'b11;
    if      (a < PI_2)  quad_c = 2'b00;
    else if (a < PI)    quad_c = 2'b01;
    else if (a < PI3_2) quad_c = 2'b10;
    case (shift_region_flag)
      2'b00:   off_c = 32'h0000_0000;
      2'b01:   off_c = PI_2;
      2'b10:   off_c = PI;
      default: off_c = PI3_2;
    endcase
  end

  // Datapath. Each register updates only in its own state and holds its
  // value in every other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a                 <= '0;
      angle_out         <= '0;
      shift_region_flag <= 2'b00;
      range_err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beg_reduce) begin
            a         <= angle_in;
            range_err <= 1'b0;
          end
        end
        WRAP: begin
          if (over_c) begin
`ifdef ANGLE_REDUCER_WRAP_EN
            // The input is below 8.0 < 4*pi, so one subtraction is enough.
            a <= a - TWO_PI;
`else
            range_err <= 1'b1;
`endif
          end
        end
        CLASS: shift_region_flag <= quad_c;
        // Subtracting the quadrant base cannot underflow, because the
        // flag was derived from this same value of a.
        SUB:   angle_out <= a - off_c;
        default: ;
      endcase
    end
  end

  // Result-valid strobe, decoded from the state alone.
  assign ready_reduce = (state == DONE);

endmodule
